// File: rtl/code_onehot_decoder_if.sv
// rtl/code_onehot_decoder_if.sv - code-in / one-hot-out handshake bundle for code_onehot_decoder
interface code_onehot_decoder_if #(
    parameter int CODE_W = 2
);
    localparam int OUT_W = 2**CODE_W;

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              in_en;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_onehot;

    modport master (
        output in_valid, in_code, in_en, out_ready,
        input  in_ready, out_valid, out_onehot
    );

    modport slave (
        input  in_valid, in_code, in_en, out_ready,
        output in_ready, out_valid, out_onehot
    );
endinterface

// File: rtl/code_onehot_decoder.sv
// rtl/code_onehot_decoder.sv - binary-to-one-hot decoder with 2-entry output FIFO and popped-word counter
module code_onehot_decoder #(
    parameter int CODE_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    code_onehot_decoder_if.slave bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     decoded_cnt,
    output logic                 cnt_sat
);
    localparam int OUT_W = 2**CODE_W;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic             r_in_ready;
    logic [OUT_W-1:0] r_head;
    logic             r_head_en;
    logic [OUT_W-1:0] r_tail;
    logic             r_tail_en;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;

    logic [OUT_W-1:0] w_decoded;
    logic [1:0]       w_state_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_out_valid;
    logic [CNT_W-1:0] w_cnt_inc;

    // Decode happens at push time so the FIFO only ever holds finished words.
    always_comb begin
        w_decoded = '0;
        for (int i = 0; i < OUT_W; i++) begin
            w_decoded[i] = bus.in_en && (bus.in_code == CODE_W'(i));
        end
    end

    assign w_out_valid = (r_state != S_EMPTY);
    assign w_push      = bus.in_valid & r_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_cnt_inc   = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_push) w_state_nxt = S_ONE;
            S_ONE: begin
                if (w_push && !w_pop)      w_state_nxt = S_FULL;
                else if (!w_push && w_pop) w_state_nxt = S_EMPTY;
            end
            S_FULL:  if (w_pop) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b0;
            r_head     <= '0;
            r_head_en  <= 1'b0;
            r_tail     <= '0;
            r_tail_en  <= 1'b0;
            r_cnt      <= '0;
            r_sat      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // Registered from next state, so out_ready never reaches in_ready combinationally.
            r_in_ready <= (w_state_nxt != S_FULL);

            // Head is never cleared on pop: in EMPTY it keeps showing the last popped word.
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_head    <= w_decoded;
                        r_head_en <= bus.in_en;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        r_head    <= w_decoded;
                        r_head_en <= bus.in_en;
                    end else if (w_push) begin
                        r_tail    <= w_decoded;
                        r_tail_en <= bus.in_en;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        r_head    <= r_tail;
                        r_head_en <= r_tail_en;
                    end
                end
                default: ;
            endcase

            if (cnt_clr) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (w_pop && r_head_en) begin
                if (r_cnt != '1) r_cnt <= w_cnt_inc;
                if ((w_cnt_inc == '1) || (r_cnt == '1)) r_sat <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_onehot = r_head;
    assign decoded_cnt    = r_cnt;
    assign cnt_sat        = r_sat;
endmodule

// File: tb/tb_code_onehot_decoder.sv
// tb/tb_code_onehot_decoder.sv - scoreboard bench for code_onehot_decoder
module tb_code_onehot_decoder;
    logic       clk;
    logic       rst;
    logic       cnt_clr;
    logic [7:0] decoded_cnt;
    logic       cnt_sat;

    int n_cmp;
    int n_bad;
    logic [3:0] sb[$];
    logic [3:0] exp_tab[4];

    code_onehot_decoder_if #(.CODE_W(2)) bus ();

    code_onehot_decoder #(.CODE_W(2), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .cnt_clr     (cnt_clr),
        .decoded_cnt (decoded_cnt),
        .cnt_sat     (cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until accepted (bounded); tracked words go to the scoreboard.
    task automatic push(input logic [1:0] c, input logic e, input logic [3:0] exp, input bit track);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_code  = c;
        bus.in_en    = e;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            check("push_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            if (track) sb.push_back(exp);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(bus.out_valid), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 32'(bus.out_onehot), 32'hdead);
            end else begin
                check("sb_word", 32'(bus.out_onehot), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        exp_tab[0] = 4'b0001;
        exp_tab[1] = 4'b0010;
        exp_tab[2] = 4'b0100;
        exp_tab[3] = 4'b1000;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        cnt_clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_code = '0;
        bus.in_en = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_onehot", 32'(bus.out_onehot), 32'd0);
        check("rst_cnt", 32'(decoded_cnt), 32'd0);
        check("rst_sat", 32'(cnt_sat), 32'd0);
        rst = 1'b0;
        tick();
        check("in_ready_rise", 32'(bus.in_ready), 32'd1);

        bus.out_ready = 1'b1;
        push(2'd2, 1'b1, 4'b0100, 1'b1);
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_onehot", 32'(bus.out_onehot), 32'h4);
        tick();
        check("single_cnt", 32'(decoded_cnt), 32'd1);

        bus.out_ready = 1'b0;
        push(2'd0, 1'b1, 4'b0001, 1'b1);
        push(2'd3, 1'b1, 4'b1000, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_code  = 2'd1;
        bus.in_en    = 1'b1;
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        check("full_still_blocked", 32'(bus.in_ready), 32'd0);
        check("full_hold_head", 32'(bus.out_onehot), 32'h1);
        bus.out_ready = 1'b1;
        push(2'd1, 1'b1, 4'b0010, 1'b1);
        drain();
        check("bp_cnt", 32'(decoded_cnt), 32'd4);

        push(2'd0, 1'b1, 4'b0001, 1'b1);
        push(2'd1, 1'b1, 4'b0010, 1'b1);
        check("stream_ready1", 32'(bus.in_ready), 32'd1);
        push(2'd2, 1'b1, 4'b0100, 1'b1);
        check("stream_ready2", 32'(bus.in_ready), 32'd1);
        push(2'd3, 1'b1, 4'b1000, 1'b1);
        check("stream_ready3", 32'(bus.in_ready), 32'd1);
        check("stream_valid", 32'(bus.out_valid), 32'd1);
        drain();
        check("stream_cnt", 32'(decoded_cnt), 32'd8);

        push(2'd3, 1'b0, 4'b0000, 1'b1);
        drain();
        check("dis_onehot", 32'(bus.out_onehot), 32'h0);
        check("dis_cnt", 32'(decoded_cnt), 32'd8);

        bus.out_ready = 1'b0;
        push(2'd1, 1'b1, 4'b0010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_onehot", 32'(bus.out_onehot), 32'h2);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        drain();
        check("hold_cnt", 32'(decoded_cnt), 32'd9);

        for (int i = 0; i < 300; i++) begin
            push(2'(i % 4), 1'b1, exp_tab[i % 4], 1'b1);
        end
        drain();
        check("sat_cnt", 32'(decoded_cnt), 32'd255);
        check("sat_flag", 32'(cnt_sat), 32'd1);

        push(2'd0, 1'b1, 4'b0001, 1'b1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_cnt", 32'(decoded_cnt), 32'd0);
        check("clr_sat", 32'(cnt_sat), 32'd0);
        check("clr_popped", 32'(bus.out_valid), 32'd0);

        bus.out_ready = 1'b0;
        push(2'd1, 1'b1, 4'b0010, 1'b0);
        push(2'd2, 1'b1, 4'b0100, 1'b0);
        check("mid_full", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_onehot", 32'(bus.out_onehot), 32'h0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("mid_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_stale", 32'(bus.out_valid), 32'd0);
        end
        push(2'd3, 1'b1, 4'b1000, 1'b1);
        drain();
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("final_cnt", 32'(decoded_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/code_onehot_decoder.md
CODE_ONEHOT_DECODER -- requirements
Module: code_onehot_decoder

Interface
REQ-001 SHALL have parameter CODE_W, default 2, binary code width; legal range 1..4.
REQ-002 SHALL have derived localparam OUT_W = 2**CODE_W, one-hot output width (default 4).
REQ-003 SHALL have parameter CNT_W, default 8, decoded-word counter width.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream code word valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port in_code  input  CODE_W  binary code to decode.
REQ-008 SHALL have port in_en  input  1  word enable; 0 means decode to all-zero.
REQ-009 SHALL have port out_valid  output  1  decoded word at FIFO head is valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts head word.
REQ-011 SHALL have port out_onehot  output  OUT_W  decoded one-hot word (registered).
REQ-012 SHALL have port cnt_clr  input  1  synchronous clear of decoded_cnt and cnt_sat.
REQ-013 SHALL have port decoded_cnt  output  CNT_W  count of words popped with in_en=1.
REQ-014 SHALL have port cnt_sat  output  1  sticky flag: decoded_cnt reached all-ones.

Function
REQ-015 Decode SHALL be: out bit [in_code] = 1 and all others 0 when in_en=1; all-zero when in_en=0. No X, no latch: every bit assigned on every path.
REQ-016 Decode SHALL occur at push time; FIFO stores the OUT_W one-hot word plus its en bit.
REQ-017 Storage SHALL be a 2-entry FIFO controlled by a 3-state FSM: EMPTY, ONE, FULL.
REQ-018 Push SHALL be in_valid & in_ready; pop SHALL be out_valid & out_ready.
REQ-019 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, and 0 while rst is high. It SHALL be registered, with no combinational path from out_ready.
REQ-020 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-021 FSM transitions SHALL be:
  - EMPTY + push -> ONE.
  - ONE + push without pop -> FULL.
  - ONE + pop without push -> EMPTY.
  - ONE + push + pop -> ONE, with the new word becoming head.
  - FULL + pop -> ONE.
  - All other cases SHALL hold state.
REQ-022 Latency SHALL be 1 cycle: a word pushed in cycle N is on out_onehot with out_valid=1 in cycle N+1 when the FIFO was EMPTY.
REQ-023 Words SHALL leave in push order, and none SHALL be dropped or duplicated.
REQ-024 out_onehot SHALL hold its value while out_valid=1 and out_ready=0. In EMPTY it SHALL hold the last popped word.
REQ-025 Counting SHALL work as follows:
  - decoded_cnt SHALL increment by 1 on each pop whose stored en bit = 1.
  - At all-ones it SHALL stay at all-ones, with no wrap, and set cnt_sat.
REQ-026 cnt_sat SHALL remain 1 until cnt_clr or rst.
REQ-027 cnt_clr in the same cycle as a counting pop SHALL win: decoded_cnt=0, cnt_sat=0, and that pop is not counted.
REQ-028 cnt_clr SHALL NOT affect FIFO contents or FSM state.

Reset
REQ-029 With rst high at a clock edge, the next state SHALL be:
  - FSM EMPTY, in_ready=0, out_valid=0, out_onehot=0, decoded_cnt=0, cnt_sat=0.
  - Any in-flight words SHALL be discarded.
REQ-030 in_ready SHALL rise to 1 on the first edge with rst low.
REQ-031 rst SHALL override a simultaneous push, pop or cnt_clr.

Verification
REQ-032 Single word: reset released, then in_code=2, in_en=1, in_valid for 1 cycle with out_ready=1 -> next cycle out_valid=1 and out_onehot=4'b0100; the cycle after, decoded_cnt=1.
REQ-033 Backpressure: out_ready=0, push codes 0, 3, 1 on consecutive cycles:
  - in_ready=0 after 2 pushes, so code 1 is not accepted.
  - Then out_ready=1 -> outputs 4'b0001, 4'b1000; code 1 is accepted when in_ready returns.
REQ-034 Simultaneous push+pop in ONE: stream codes 0, 1, 2, 3 with both ready -> one word per cycle, outputs 0001, 0010, 0100, 1000, state stays ONE.
REQ-035 Disabled words: push code 3 with in_en=0 -> out_onehot=4'b0000; decoded_cnt unchanged.
REQ-036 Saturation/clear:
  - 300 enabled pops -> decoded_cnt=255, cnt_sat=1.
  - cnt_clr asserted together with a pop -> decoded_cnt=0, cnt_sat=0.
REQ-037 Reset mid-operation: FIFO FULL, assert rst for 1 cycle -> out_valid=0, out_onehot=0, in_ready=0; the next cycle in_ready=1 and no stale word emerges.
